// File: rtl/uart_line_assembler_pkg.sv
// uart_line_assembler shared definitions.
// ASCII codes, FSM states and a width helper.
package uart_line_assembler_pkg;

  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_DEL   = 8'h7F;
  localparam logic [7:0] CHR_SP    = 8'h20;
  localparam logic [7:0] CHR_TILDE = 8'h7E;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Number of bits needed to write v in binary.
  function automatic int bit_count(input int v);
    int n;
    int x;
    n = 0;
    x = v;
    while (x > 0) begin
      n++;
      x = x >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/uart_line_assembler_if.sv
// Byte stream in, held line and read port out.
// master = uart_rx/consumer side, slave = assembler.
interface uart_line_assembler_if #(
  parameter int MAX_LEN = 64
);
  import uart_line_assembler_pkg::*;

  localparam int LEN_W = bit_count(MAX_LEN);
  localparam int AW    = bit_count(MAX_LEN - 1);

  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             line_valid;
  logic [LEN_W-1:0] line_len;
  logic             line_overflow;
  logic             line_ack;
  logic [AW-1:0]    rd_addr;
  logic [7:0]       rd_data;
  logic [7:0]       drop_cnt;

  modport master (
    output rx_ready, rx_data, line_ack, rd_addr,
    input  line_valid, line_len, line_overflow,
    input  rd_data, drop_cnt
  );

  modport slave (
    input  rx_ready, rx_data, line_ack, rd_addr,
    output line_valid, line_len, line_overflow,
    output rd_data, drop_cnt
  );

endinterface

// File: rtl/uart_line_assembler_buf.sv
// Line buffer: one write port, one registered read port.
// A read of the address being written returns the old byte.
module uart_line_assembler_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata <= 8'h00;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_line_assembler.sv
// Edits the uart_rx byte stream into a line and
// holds it until the consumer acknowledges.
module uart_line_assembler
  import uart_line_assembler_pkg::*;
#(
  parameter int MAX_LEN = 64
) (
  input logic                  clk,
  input logic                  rst,
  uart_line_assembler_if.slave bus
);

  localparam int LEN_W = bit_count(MAX_LEN);
  localparam int AW    = bit_count(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic             valid_q;
  logic             ovf_q;
  logic [7:0]       drop_q;

  logic printable;
  logic is_bs;
  logic is_term;
  logic wr_en;

  assign printable = (bus.rx_data >= CHR_SP) &&
                     (bus.rx_data <= CHR_TILDE);
  assign is_bs     = (bus.rx_data == CHR_BS) ||
                     (bus.rx_data == CHR_DEL);
  assign is_term   = (bus.rx_data == CHR_CR) ||
                     (bus.rx_data == CHR_LF);
  assign wr_en     = (state == S_FILL) && bus.rx_ready &&
                     printable && (len < FULL);

  uart_line_assembler_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (len[AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FILL;
      len     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      unique case (state)
        S_FILL: begin
          if (bus.rx_ready) begin
            unique case (1'b1)
              printable: begin
                if (len < FULL)
                  len <= len + LEN_W'(1);
                else
                  ovf_q <= 1'b1;
              end
              is_bs: begin
                if (len != '0)
                  len <= len - LEN_W'(1);
              end
              is_term: begin
                if (len != '0) begin
                  state   <= S_HOLD;
                  valid_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_HOLD: begin
          // Strobes here are lost; count them even on the ack cycle.
          if (bus.rx_ready && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
          if (bus.line_ack) begin
            state   <= S_FILL;
            len     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.line_valid    = valid_q;
  assign bus.line_len      = len;
  assign bus.line_overflow = ovf_q;
  assign bus.drop_cnt      = drop_q;

endmodule
